// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronise, debounce and edge-detect push buttons.
// Define KEY_CONDITIONER_REPEAT_EN to enable auto-repeat on held keys.
module key_conditioner #(
    parameter int KEYS            = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [KEYS-1:0] key_n,
    output logic [KEYS-1:0] key_level,
    output logic [KEYS-1:0] key_press,
    output logic [KEYS-1:0] key_release,
    output logic [KEYS-1:0] key_repeat,
    output logic            any_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    if (KEYS < 1 || KEYS > 8 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24) ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("key_conditioner: parameter out of range");
    end

    logic [KEYS-1:0] sync_q1;
    logic [KEYS-1:0] sync;
    logic [CW-1:0]   db_cnt [KEYS];
    logic [KEYS-1:0] differs;
    logic [KEYS-1:0] done;
    logic [KEYS-1:0] accept_press;
    logic [KEYS-1:0] accept_release;
    logic [KEYS-1:0] repeat_fire;
    logic [KEYS-1:0] press_nxt;

    // Idle (released) level of an active-low pin is 1, so the flops reset high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '1;
            sync    <= '1;
        end else begin
            sync_q1 <= key_n;
            sync    <= sync_q1;
        end
    end

    // sync is active-low and key_level active-high: equal bits mean a pending change.
    always_comb begin
        differs        = '0;
        done           = '0;
        accept_press   = '0;
        accept_release = '0;
        for (int i = 0; i < KEYS; i++) begin
            differs[i] = (sync[i] == key_level[i]);
            done[i]    = differs[i] && (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
        accept_press   = done & ~key_level;
        accept_release = done & key_level;
        press_nxt      = accept_press | repeat_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEYS; i++) begin
                db_cnt[i] <= '0;
            end
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_press   <= 1'b0;
        end else begin
            for (int i = 0; i < KEYS; i++) begin
                if (!differs[i] || done[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
            key_level   <= key_level ^ done;
            key_press   <= press_nxt;
            key_release <= accept_release;
            any_press   <= |press_nxt;
        end
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX);

    logic [RW-1:0]   rpt_cnt [KEYS];
    logic [KEYS-1:0] rpt_armed;
    logic [KEYS-1:0] rpt_hit;

    // rpt_armed selects the period once the first (longer) delay has elapsed.
    always_comb begin
        rpt_hit     = '0;
        repeat_fire = '0;
        for (int i = 0; i < KEYS; i++) begin
            rpt_hit[i] = key_level[i] &&
                         (rpt_cnt[i] == (rpt_armed[i] ? RW'(REPEAT_PERIOD - 1)
                                                      : RW'(REPEAT_DELAY - 1)));
        end
        repeat_fire = rpt_hit & ~accept_release;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEYS; i++) begin
                rpt_cnt[i] <= '0;
            end
            rpt_armed  <= '0;
            key_repeat <= '0;
        end else begin
            for (int i = 0; i < KEYS; i++) begin
                if (!key_level[i] || accept_release[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_armed[i] <= 1'b0;
                end else if (rpt_hit[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_armed[i] <= 1'b1;
                end else begin
                    rpt_cnt[i]   <= rpt_cnt[i] + RW'(1);
                end
            end
            key_repeat <= repeat_fire;
        end
    end
`else
    assign repeat_fire = '0;
    assign key_repeat  = '0;
`endif

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL provide parameter KEYS, default 4, number of independent push-button channels (1..8).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required before a level change is accepted (2..2^24).
REQ-003 SHALL provide parameter REPEAT_DELAY, default 25000000, held cycles from the initial press pulse to the first repeat pulse (>=2).
REQ-004 SHALL provide parameter REPEAT_PERIOD, default 5000000, cycles between subsequent repeat pulses (>=2).
REQ-005 SHALL provide port clk, input, 1, single system clock; all state is clocked on its rising edge.
REQ-006 SHALL provide port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL provide port key_n, input, KEYS, raw active-low button pins, asynchronous to clk.
REQ-008 SHALL provide port key_level, output, KEYS, debounced level; 1 = pressed.
REQ-009 SHALL provide port key_press, output, KEYS, one-cycle pulse per accepted press and per repeat.
REQ-010 SHALL provide port key_release, output, KEYS, one-cycle pulse per accepted release.
REQ-011 SHALL provide port key_repeat, output, KEYS, one-cycle pulse marking key_press pulses that came from auto-repeat.
REQ-012 SHALL provide port any_press, output, 1, registered OR of key_press.

Function
REQ-013 Each bit of key_n SHALL pass through a two-flop synchronizer; the debounce logic SHALL use only the second-stage output (sync).
REQ-014 Each channel SHALL hold a debounce counter sized $clog2(DEBOUNCE_CYCLES); on an edge where sync equals the inverted key_level, the counter SHALL clear to 0.
REQ-015 On an edge where sync differs from the inverted key_level, the counter SHALL increment; when the counter equals DEBOUNCE_CYCLES-1 on such an edge, key_level SHALL toggle and the counter SHALL clear.
REQ-016 Latency: key_n low first sampled at edge 0 and held SHALL give key_level=1 and key_press=1 after edge DEBOUNCE_CYCLES+1; release SHALL be symmetric, with key_release in place of key_press.
REQ-017 Any single-cycle return of sync to the accepted level during counting SHALL restart the count from 0; glitches shorter than DEBOUNCE_CYCLES SHALL produce no output activity.
REQ-018 key_press and key_release SHALL be registered, high exactly one cycle, and never both high on the same channel in the same cycle.
REQ-019 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses, with none dropped or serialized.
REQ-020 any_press SHALL assert in the same cycle as any key_press bit.

Reset
REQ-021 While rst_n=0: synchronizer flops SHALL be 1; key_level, key_press, key_release, key_repeat, any_press SHALL be 0; all counters SHALL be 0.
REQ-022 Reset asserted mid-count or mid-hold SHALL abort immediately, with no pulse emitted for the aborted event.
REQ-023 A key held through reset release SHALL produce exactly one key_press after edge DEBOUNCE_CYCLES+2, counting the first edge after release as edge 1.

Configuration
REQ-024 With macro KEY_CONDITIONER_REPEAT_EN defined: while key_level=1, a per-channel repeat counter SHALL run; REPEAT_DELAY cycles after the accepted press pulse, and every REPEAT_PERIOD cycles thereafter, key_press and key_repeat SHALL pulse together for one cycle.
REQ-025 With the macro defined, the repeat counter SHALL clear on release acceptance and on reset, and a release accepted in the same cycle a repeat would fire SHALL suppress that repeat.
REQ-026 Without the macro: key_repeat SHALL be tied to 0, no repeat logic SHALL be synthesized, and exactly one key_press SHALL occur per accepted press.

Verification
REQ-027 Settings DEBOUNCE_CYCLES=4, KEYS=4. Key0 low from edge 0 -> key_level[0] and key_press[0] high after edge 5; key_press[0] low after edge 6.
REQ-028 Key1 bounces low 3 cycles / high 1 cycle, 5 times, then stays low -> exactly one key_press[1], 5 cycles after the final low transition reaches sync.
REQ-029 Keys 0 and 3 pressed on the same edge -> key_press=4'b1001 in a single cycle; any_press=1 in that cycle.
REQ-030 Release key0 after hold -> key_release[0] after edge 5 of the release; key_level[0]=0; key_press stays 0.
REQ-031 rst_n pulsed low at count 2 of a press -> outputs 0 at once; with key still held, one key_press after edge 6 following reset release.
REQ-032 With the macro defined, REPEAT_DELAY=10 and REPEAT_PERIOD=3, held key2 -> key_press[2] pulses at T, T+10, T+13, T+16; key_repeat[2] is high on all pulses except T.
